// File: rtl/cmd_exec_pkg.sv
// Shared definitions for the cmd_exec execute sequencer: opcodes, FSM states and
// the write-back classification helper.
package cmd_exec_pkg;

    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_DEC = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WB
    } state_e;

    // Opcodes above OP_DEC are NOPs and never touch the register file or flags.
    function automatic logic op_writes(input logic [3:0] opcode);
        return (opcode <= OP_DEC);
    endfunction

endpackage

// File: rtl/cmd_exec_alu.sv
// Combinational 8-bit ALU for cmd_exec. Every operation is evaluated as a 9-bit
// value whose top bit is the carry/borrow flag.
module alu8
    import cmd_exec_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic       c
);

    logic [8:0] wide;

    always_comb begin
        wide = 9'd0;
        case (op)
            OP_MOV:  wide = {1'b0, b};
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_NOT:  wide = {1'b0, ~a};
            OP_SHL:  wide = {a, 1'b0};
            // Shifted-out LSB lands in the carry position.
            OP_SHR:  wide = {a[0], 1'b0, a[7:1]};
            OP_INC:  wide = {1'b0, a} + 9'd1;
            OP_DEC:  wide = {1'b0, a} - 9'd1;
            default: wide = 9'd0;
        endcase
    end

    assign y = wide[7:0];
    assign c = wide[8];

endmodule

// File: rtl/cmd_exec.sv
// Four-phase execute sequencer: latches an instruction, captures operands from the
// register file, runs the ALU and issues a single active-low write-back strobe.
module cmd_exec
    import cmd_exec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] instr,
    input  logic [7:0] R0,
    input  logic [7:0] R1,
    input  logic [7:0] R2,
    input  logic [7:0] R3,
    output logic [7:0] res_alu,
    output logic [1:0] res_dest,
    output logic       enact,
    output logic       busy,
    output logic       done,
    output logic       flag_z,
    output logic       flag_c
);

    state_e     state_q, state_d;
    logic [7:0] instr_q;
    logic [7:0] a_q, b_q;
    logic [7:0] res_alu_q;
    logic [1:0] res_dest_q;
    logic       enact_q;
    logic       done_q;
    logic       flag_z_q, flag_c_q;

    logic [3:0] opcode;
    logic [1:0] rd, rs;
    logic [7:0] rd_val, rs_val;
    logic [7:0] alu_y;
    logic       alu_c;

    assign opcode = instr_q[7:4];
    assign rd     = instr_q[3:2];
    assign rs     = instr_q[1:0];

    always_comb begin
        rd_val = R0;
        case (rd)
            2'd0:    rd_val = R0;
            2'd1:    rd_val = R1;
            2'd2:    rd_val = R2;
            default: rd_val = R3;
        endcase
    end

    always_comb begin
        rs_val = R0;
        case (rs)
            2'd0:    rs_val = R0;
            2'd1:    rs_val = R1;
            2'd2:    rs_val = R2;
            default: rs_val = R3;
        endcase
    end

    alu8 u_alu (
        .op (opcode),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y),
        .c  (alu_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            instr_q    <= 8'h00;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            res_alu_q  <= 8'h00;
            res_dest_q <= 2'd0;
            enact_q    <= 1'b1;
            done_q     <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) instr_q <= instr;
                end
                ST_FETCH: begin
                    a_q <= rd_val;
                    b_q <= rs_val;
                end
                ST_EXEC: begin
                    // Destination follows Rd even for NOPs; data and flags only on writes.
                    res_dest_q <= rd;
                    if (op_writes(opcode)) begin
                        res_alu_q <= alu_y;
                        flag_c_q  <= alu_c;
                        flag_z_q  <= (alu_y == 8'h00);
                        enact_q   <= 1'b0;
                    end
                end
                ST_WB: begin
                    enact_q <= 1'b1;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign res_alu  = res_alu_q;
    assign res_dest = res_dest_q;
    assign enact    = enact_q;
    assign done     = done_q;
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmd_exec.sv
// Directed self-checking bench for cmd_exec; models the downstream register file
// by applying each observed write-back strobe.
module tb_cmd_exec;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] instr;
    logic [7:0] rf [4];
    logic [7:0] res_alu;
    logic [1:0] res_dest;
    logic       enact, busy, done, flag_z, flag_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmd_exec u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .instr    (instr),
        .R0       (rf[0]),
        .R1       (rf[1]),
        .R2       (rf[2]),
        .R3       (rf[3]),
        .res_alu  (res_alu),
        .res_dest (res_dest),
        .enact    (enact),
        .busy     (busy),
        .done     (done),
        .flag_z   (flag_z),
        .flag_c   (flag_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full instruction from an idle sequencer; applies any write-back to rf.
    task automatic run_instr(input string tag, input logic [7:0] ins, input logic exp_we,
                             input logic [1:0] exp_dest, input logic [7:0] exp_res,
                             input logic exp_z, input logic exp_c);
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        @(negedge clk);
        start = 1'b1;
        instr = ins;
        @(posedge clk);
        #1;
        start = 1'b0;
        instr = 8'h00;
        check({tag, "_n0_busy"}, busy, 1);
        check({tag, "_n0_enact"}, enact, 1);
        @(posedge clk);
        #1;
        check({tag, "_n1_enact"}, enact, 1);
        check({tag, "_n1_done"}, done, 0);
        @(posedge clk);
        #1;
        check({tag, "_n2_enact"}, enact, !exp_we);
        check({tag, "_n2_dest"}, res_dest, exp_dest);
        check({tag, "_n2_res"}, res_alu, exp_res);
        check({tag, "_n2_z"}, flag_z, exp_z);
        check({tag, "_n2_c"}, flag_c, exp_c);
        we = !enact;
        wa = res_dest;
        wd = res_alu;
        @(posedge clk);
        if (we) rf[wa] = wd;
        #1;
        check({tag, "_n3_enact"}, enact, 1);
        check({tag, "_n3_done"}, done, 1);
        check({tag, "_n3_busy"}, busy, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        instr = 8'h00;
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", res_alu, 0);
        check("rst_dest", res_dest, 0);
        check("rst_enact", enact, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_z", flag_z, 0);
        check("rst_c", flag_c, 0);
        @(negedge clk);
        rst = 1'b0;

        rf[1] = 8'h7F;
        rf[2] = 8'h81;
        run_instr("add", 8'h16, 1'b1, 2'd1, 8'h00, 1'b1, 1'b1);
        check("add_rf1", rf[1], 8'h00);

        rf[0] = 8'h03;
        rf[3] = 8'h05;
        run_instr("sub", 8'h23, 1'b1, 2'd0, 8'hFE, 1'b0, 1'b1);

        // NOP with start held high for the whole instruction and beyond.
        @(negedge clk);
        start = 1'b1;
        instr = 8'hF5;
        @(posedge clk);
        #1;
        check("nop_n0_busy", busy, 1);
        @(posedge clk);
        #1;
        check("nop_n1_enact", enact, 1);
        check("nop_n1_done", done, 0);
        @(posedge clk);
        #1;
        check("nop_n2_enact", enact, 1);
        check("nop_n2_dest", res_dest, 1);
        check("nop_n2_res", res_alu, 8'hFE);
        check("nop_n2_z", flag_z, 0);
        check("nop_n2_c", flag_c, 1);
        check("nop_n2_done", done, 0);
        @(posedge clk);
        #1;
        check("nop_n3_done", done, 1);
        check("nop_n3_busy", busy, 0);
        check("nop_n3_enact", enact, 1);
        @(posedge clk);
        #1;
        check("nop_n4_busy", busy, 1);
        check("nop_n4_done", done, 0);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("nop2_done", done, 1);
        check("nop2_enact", enact, 1);

        rf[2] = 8'h81;
        run_instr("shl", 8'h7A, 1'b1, 2'd2, 8'h02, 1'b0, 1'b1);
        check("shl_rf2", rf[2], 8'h02);
        run_instr("shr", 8'h8A, 1'b1, 2'd2, 8'h01, 1'b0, 1'b0);

        // Reset asserted in the EXEC cycle of an ADD.
        rf[1] = 8'h7F;
        rf[2] = 8'h81;
        @(negedge clk);
        start = 1'b1;
        instr = 8'h16;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("mid_exec_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_enact", enact, 1);
        check("mid_busy", busy, 0);
        check("mid_res", res_alu, 0);
        check("mid_c", flag_c, 0);
        check("mid_done", done, 0);
        @(posedge clk);
        #1;
        check("mid_enact2", enact, 1);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rf1", rf[1], 8'h7F);
        run_instr("add2", 8'h16, 1'b1, 2'd1, 8'h00, 1'b1, 1'b1);

        rf[0] = 8'hFF;
        run_instr("inc", 8'h90, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1);
        run_instr("mov", 8'h04, 1'b1, 2'd1, 8'h00, 1'b1, 1'b0);

        rf[3] = 8'h00;
        run_instr("dec", 8'hAF, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b1);
        run_instr("not", 8'h6C, 1'b1, 2'd3, 8'h00, 1'b1, 1'b0);
        check("not_rf3", rf[3], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
